// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: two-approach intersection scheduler with a seconds prescaler,
// a phase down-counter, pedestrian request latches and registered one-hot lamp outputs.
module traffic_intersection_ctrl #(
    parameter int CLK_PER_SEC = 50000000,
    parameter int GREEN_SEC   = 20,
    parameter int YELLOW_SEC  = 3,
    parameter int ALLRED_SEC  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ped_req_ns,
    input  logic             ped_req_ew,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             walk_ns,
    output logic             walk_ew,
    output logic             sec_tick,
    output logic [CNT_W-1:0] remain
);
    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'((CLK_PER_SEC > 1) ? CLK_PER_SEC - 1 : 0);
    localparam logic [CNT_W-1:0] G_D = CNT_W'((GREEN_SEC  == 0) ? 1 : GREEN_SEC);
    localparam logic [CNT_W-1:0] Y_D = CNT_W'((YELLOW_SEC == 0) ? 1 : YELLOW_SEC);
    localparam logic [CNT_W-1:0] R_D = CNT_W'((ALLRED_SEC == 0) ? 1 : ALLRED_SEC);
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    typedef enum logic [2:0] {IDLE, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic [CNT_W-1:0] remain_nx;
    logic             tick_nx, enter, last;
    logic             req_ns, req_ew, req_ns_nx, req_ew_nx;
    logic             walk_ns_nx, walk_ew_nx;
    logic [2:0]       ns_nx, ew_nx;

    function automatic state_t succ(input state_t s);
        case (s)
            NS_G:    succ = NS_Y;
            NS_Y:    succ = AR1;
            AR1:     succ = EW_G;
            EW_G:    succ = EW_Y;
            EW_Y:    succ = AR2;
            default: succ = NS_G;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] dur(input state_t s);
        dur = (s == NS_G || s == EW_G) ? G_D : (s == NS_Y || s == EW_Y) ? Y_D : R_D;
    endfunction

    assign last = (presc == P_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        presc_nx   = presc;
        remain_nx  = remain;
        tick_nx    = 1'b0;
        enter      = 1'b0;
        req_ns_nx  = req_ns | ped_req_ns;
        req_ew_nx  = req_ew | ped_req_ew;
        walk_ns_nx = walk_ns;
        walk_ew_nx = walk_ew;
        if (!en) begin
            state_nx  = IDLE;
            presc_nx  = '0;
            remain_nx = '0;
        end else if (state == IDLE) begin
            state_nx = NS_G;
            enter    = 1'b1;
        end else begin
            presc_nx = last ? '0 : presc + 1'b1;
            if (last) begin
                tick_nx   = 1'b1;
                remain_nx = remain - 1'b1;
                // remain==0 cannot occur outside IDLE; treat it like 1 so the FSM never stalls
                if (remain == CNT_W'(1) || remain == '0) begin
                    state_nx = succ(state);
                    enter    = 1'b1;
                end
            end
        end
        if (enter) begin
            presc_nx  = '0;
            remain_nx = dur(state_nx);
        end
        if (enter && state_nx == NS_G) begin
            walk_ns_nx = req_ns | ped_req_ns;
            req_ns_nx  = 1'b0;
        end
        if (enter && state_nx == EW_G) begin
            walk_ew_nx = req_ew | ped_req_ew;
            req_ew_nx  = 1'b0;
        end
        if (state_nx != NS_G) walk_ns_nx = 1'b0;
        if (state_nx != EW_G) walk_ew_nx = 1'b0;
        ns_nx = (state_nx == NS_G) ? GRN : (state_nx == NS_Y) ? YEL : RED;
        ew_nx = (state_nx == EW_G) ? GRN : (state_nx == EW_Y) ? YEL : RED;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= '0;
            remain   <= '0;
            sec_tick <= 1'b0;
            req_ns   <= 1'b0;
            req_ew   <= 1'b0;
            walk_ns  <= 1'b0;
            walk_ew  <= 1'b0;
            ns_light <= RED;
            ew_light <= RED;
        end else begin
            presc    <= presc_nx;
            remain   <= remain_nx;
            sec_tick <= tick_nx;
            req_ns   <= req_ns_nx;
            req_ew   <= req_ew_nx;
            walk_ns  <= walk_ns_nx;
            walk_ew  <= walk_ew_nx;
            ns_light <= ns_nx;
            ew_light <= ew_nx;
        end
    end
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: scoreboard bench; a cycle-count reference model pushes the
// expected outputs for every driven edge, a monitor pops and compares after the edge.
module tb_traffic_intersection_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, en = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0;
    logic [2:0] ns_light, ew_light;
    logic       walk_ns, walk_ew, sec_tick;
    logic [7:0] remain;

    int vectors = 0, miscompares = 0;
    logic [16:0] exp_q[$];

    int   m_ph = 0, m_k = 0;
    logic m_rn = 0, m_re = 0, m_wn = 0, m_we = 0, m_tick = 0;
    logic prev_tick = 0;

    traffic_intersection_ctrl #(.CLK_PER_SEC(4), .GREEN_SEC(3), .YELLOW_SEC(2),
                                .ALLRED_SEC(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .ns_light(ns_light), .ew_light(ew_light), .walk_ns(walk_ns), .walk_ew(walk_ew),
        .sec_tick(sec_tick), .remain(remain)
    );

    always #5 clk = ~clk;

    function automatic int dsec(input int ph);
        return (ph == 1 || ph == 4) ? 3 : (ph == 2 || ph == 5) ? 2 : 1;
    endfunction

    function automatic logic [16:0] model_out();
        logic [2:0] n, e;
        logic [7:0] r;
        n = (m_ph == 1) ? 3'b001 : (m_ph == 2) ? 3'b010 : 3'b100;
        e = (m_ph == 4) ? 3'b001 : (m_ph == 5) ? 3'b010 : 3'b100;
        r = (m_ph == 0) ? 8'd0 : 8'(dsec(m_ph) - m_k / 4);
        return {n, e, m_wn, m_we, m_tick, r};
    endfunction

    // one clock edge: drive inputs, advance the model, queue its prediction
    task automatic tick(input logic e, input logic pn, input logic pe, input logic r);
        logic ent;
        @(negedge clk);
        rst_n = r; en = e; ped_req_ns = pn; ped_req_ew = pe;
        ent = 1'b0;
        if (!r) begin
            m_ph = 0; m_k = 0; m_rn = 0; m_re = 0; m_wn = 0; m_we = 0; m_tick = 0;
        end else begin
            m_rn = m_rn | pn;
            m_re = m_re | pe;
            if (!e) begin
                m_ph = 0; m_k = 0; m_tick = 0;
            end else if (m_ph == 0) begin
                m_ph = 1; m_k = 0; m_tick = 0; ent = 1'b1;
            end else begin
                m_k++;
                m_tick = (m_k % 4 == 0);
                if (m_k == dsec(m_ph) * 4) begin
                    m_ph = (m_ph == 6) ? 1 : m_ph + 1;
                    m_k = 0;
                    ent = 1'b1;
                end
            end
            if (ent && m_ph == 1) begin m_wn = m_rn; m_rn = 0; end
            if (ent && m_ph == 4) begin m_we = m_re; m_re = 0; end
            if (m_ph != 1) m_wn = 0;
            if (m_ph != 4) m_we = 0;
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 1);
    endtask

    always @(posedge clk) begin
        logic [16:0] exp_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            vectors++;
            if ({ns_light, ew_light, walk_ns, walk_ew, sec_tick, remain} !== exp_v) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got ns=%b ew=%b wn=%b we=%b tk=%b rem=%0d exp ns=%b ew=%b wn=%b we=%b tk=%b rem=%0d",
                         $time, ns_light, ew_light, walk_ns, walk_ew, sec_tick, remain,
                         exp_v[16:14], exp_v[13:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 || $time > 20) begin
            vectors++;
            if (!$onehot(ns_light) || !$onehot(ew_light) ||
                (ns_light != 3'b100 && ew_light != 3'b100) || (sec_tick && prev_tick)) begin
                miscompares++;
                $display("FAIL invariant t=%0t got ns=%b ew=%b tick=%b prev_tick=%b exp one-hot, one red, no double tick",
                         $time, ns_light, ew_light, sec_tick, prev_tick);
            end
            prev_tick = sec_tick;
        end
    end

    task automatic test_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        vectors++;
        if (ns_light !== 3'b100 || ew_light !== 3'b100 || remain !== 8'd0 || walk_ns !== 1'b0 ||
            walk_ew !== 1'b0 || sec_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset got ns=%b ew=%b rem=%0d wn=%b we=%b tk=%b exp 100 100 0 0 0 0",
                     ns_light, ew_light, remain, walk_ns, walk_ew, sec_tick);
        end
    endtask

    task automatic test_cycle();
        tick(1, 0, 0, 1);
        vectors++;
        if (ns_light !== 3'b001 || remain !== 8'd3) begin
            miscompares++;
            $display("FAIL ns_g_entry got ns=%b rem=%0d exp 001 3", ns_light, remain);
        end
        run(47);
        vectors++;
        if (ns_light !== 3'b100 || ew_light !== 3'b100 || remain !== 8'd1) begin
            miscompares++;
            $display("FAIL ar2_end got ns=%b ew=%b rem=%0d exp 100 100 1", ns_light, ew_light, remain);
        end
        run(1);
        vectors++;
        if (ns_light !== 3'b001 || remain !== 8'd3 || sec_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL ns_g_reentry_49 got ns=%b rem=%0d tk=%b exp 001 3 1", ns_light, remain, sec_tick);
        end
    endtask

    task automatic test_ped_ew();
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 1);
        run(13);
        tick(1, 0, 1, 1);
        run(9);
        for (int i = 0; i < 12; i++) begin
            run(1);
            vectors++;
            if (walk_ew !== 1'b1 || ew_light !== 3'b001) begin
                miscompares++;
                $display("FAIL walk_ew_served cyc=%0d got we=%b ew=%b exp 1 001", i, walk_ew, ew_light);
            end
        end
        run(1);
        vectors++;
        if (walk_ew !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_ew_drop got %b exp 0", walk_ew);
        end
        run(36);
        vectors++;
        if (walk_ew !== 1'b0 || ew_light !== 3'b001) begin
            miscompares++;
            $display("FAIL walk_ew_next_phase got we=%b ew=%b exp 0 001", walk_ew, ew_light);
        end
    endtask

    task automatic test_ped_ns();
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 1);
        vectors++;
        if (walk_ns !== 1'b1) begin
            miscompares++;
            $display("FAIL walk_ns_same_edge got %b exp 1", walk_ns);
        end
        run(3);
        tick(1, 1, 0, 1);
        vectors++;
        if (walk_ns !== 1'b1) begin
            miscompares++;
            $display("FAIL walk_ns_hold got %b exp 1", walk_ns);
        end
        run(7);
        run(1);
        vectors++;
        if (walk_ns !== 1'b0 || ns_light !== 3'b010) begin
            miscompares++;
            $display("FAIL walk_ns_drop got wn=%b ns=%b exp 0 010", walk_ns, ns_light);
        end
        run(36);
        vectors++;
        if (walk_ns !== 1'b1 || ns_light !== 3'b001) begin
            miscompares++;
            $display("FAIL walk_ns_next_phase got wn=%b ns=%b exp 1 001", walk_ns, ns_light);
        end
    endtask

    task automatic test_enable_reset();
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 1);
        run(29);
        tick(0, 0, 0, 1);
        vectors++;
        if (ns_light !== 3'b100 || ew_light !== 3'b100 || remain !== 8'd0) begin
            miscompares++;
            $display("FAIL en_low got ns=%b ew=%b rem=%0d exp 100 100 0", ns_light, ew_light, remain);
        end
        tick(1, 0, 0, 1);
        vectors++;
        if (ns_light !== 3'b001 || remain !== 8'd3) begin
            miscompares++;
            $display("FAIL reenable got ns=%b rem=%0d exp 001 3", ns_light, remain);
        end
        run(13);
        tick(1, 1, 0, 1);
        run(1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 1);
        vectors++;
        if (walk_ns !== 1'b0 || ns_light !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_clears_latch got wn=%b ns=%b exp 0 001", walk_ns, ns_light);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++)
            tick(($urandom_range(0, 99) < 97), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 999) != 0));
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ped_ew();
        test_ped_ns();
        test_enable_reset();
        test_random();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
